// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART frame parser.
package uart_frame_pkg;

    typedef enum logic [2:0] {
        HUNT,
        LEN,
        PAYLOAD,
        CHK,
        DRAIN
    } frame_state_e;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_LEN  = 2'd1;
    localparam logic [1:0] ERR_CHK  = 2'd2;
    localparam logic [1:0] ERR_TMO  = 2'd3;

    localparam logic [7:0] SOF_DEFAULT = 8'h7E;

    // Address width for a buffer of the given depth (at least one bit).
    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/uart_frame_buf.sv
// Payload buffer: DEPTH x DBIT register file, synchronous write, asynchronous read.
module uart_frame_buf #(
    parameter int DEPTH = 16,
    parameter int DBIT  = 8,
    parameter int AW    = 4
) (
    input  logic            clk,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [DBIT-1:0] wdata,
    input  logic [AW-1:0]   raddr,
    output logic [DBIT-1:0] rdata
);

    logic [DBIT-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_frame_parser.sv
// Pops UART RX FIFO bytes, parses SOF/LEN/payload/CHK frames, streams verified payloads.
// Optional inter-byte timeout is built only when UART_FRAME_TIMEOUT_EN is defined.
//
// state   | meaning
// HUNT    | popping and discarding bytes until SOF
// LEN     | next popped byte is the payload length
// PAYLOAD | storing payload bytes into the buffer, folding into chk
// CHK     | next popped byte is compared with the running XOR
// DRAIN   | streaming the buffered payload downstream, no FIFO pops
module uart_frame_parser
    import uart_frame_pkg::*;
#(
    parameter int         DBIT        = 8,
    parameter logic [7:0] SOF         = SOF_DEFAULT,
    parameter int         MAX_LEN     = 16,
    parameter int         TIMEOUT_CYC = 52160
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rx_empty,
    input  logic [DBIT-1:0] rx_data,
    output logic            rd_uart,
    output logic [DBIT-1:0] m_data,
    output logic            m_valid,
    input  logic            m_ready,
    output logic            m_last,
    output logic            frame_ok,
    output logic            frame_err,
    output logic [1:0]      err_code,
    output logic [15:0]     frame_cnt,
    output logic [15:0]     err_cnt
);

    localparam int         AW        = addr_w(MAX_LEN);
    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    frame_state_e    state;
    logic [7:0]      len;
    logic [7:0]      idx;
    logic [7:0]      rd_idx;
    logic [DBIT-1:0] chk;
    logic [DBIT-1:0] buf_rdata;
    logic            buf_we;

    assign rd_uart = !rx_empty && (state != DRAIN);
    assign buf_we  = rd_uart && (state == PAYLOAD);
    assign m_valid = (state == DRAIN);
    assign m_data  = m_valid ? buf_rdata : '0;
    assign m_last  = m_valid && (rd_idx == len - 8'd1);

    uart_frame_buf #(
        .DEPTH (MAX_LEN),
        .DBIT  (DBIT),
        .AW    (AW)
    ) u_buf (
        .clk   (clk),
        .we    (buf_we),
        .waddr (idx[AW-1:0]),
        .wdata (rx_data),
        .raddr (rd_idx[AW-1:0]),
        .rdata (buf_rdata)
    );

`ifdef UART_FRAME_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] tmo_cnt;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYC;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= HUNT;
            len       <= '0;
            idx       <= '0;
            rd_idx    <= '0;
            chk       <= '0;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            err_code  <= ERR_NONE;
            frame_cnt <= '0;
            err_cnt   <= '0;
`ifdef UART_FRAME_TIMEOUT_EN
            tmo_cnt   <= '0;
`endif
        end else begin
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;

            case (state)
                HUNT: begin
                    if (rd_uart && rx_data == SOF) begin
                        state <= LEN;
                    end
                end
                LEN: begin
                    if (rd_uart) begin
                        // The rejected length byte is consumed, never re-tested as SOF.
                        if (rx_data == '0 || rx_data > MAX_LEN_B) begin
                            frame_err <= 1'b1;
                            err_code  <= ERR_LEN;
                            err_cnt   <= err_cnt + 16'd1;
                            state     <= HUNT;
                        end else begin
                            len   <= rx_data;
                            chk   <= rx_data;
                            idx   <= '0;
                            state <= PAYLOAD;
                        end
                    end
                end
                PAYLOAD: begin
                    if (rd_uart) begin
                        chk <= chk ^ rx_data;
                        idx <= idx + 8'd1;
                        if (idx == len - 8'd1) begin
                            state <= CHK;
                        end
                    end
                end
                CHK: begin
                    if (rd_uart) begin
                        if (rx_data == chk) begin
                            frame_ok  <= 1'b1;
                            frame_cnt <= frame_cnt + 16'd1;
                            rd_idx    <= '0;
                            state     <= DRAIN;
                        end else begin
                            frame_err <= 1'b1;
                            err_code  <= ERR_CHK;
                            err_cnt   <= err_cnt + 16'd1;
                            state     <= HUNT;
                        end
                    end
                end
                DRAIN: begin
                    if (m_ready) begin
                        rd_idx <= rd_idx + 8'd1;
                        if (rd_idx == len - 8'd1) begin
                            state <= HUNT;
                        end
                    end
                end
                default: state <= HUNT;
            endcase

`ifdef UART_FRAME_TIMEOUT_EN
            // Silence mid-frame; a pop in the same cycle always wins.
            if (state == LEN || state == PAYLOAD || state == CHK) begin
                if (rd_uart) begin
                    tmo_cnt <= '0;
                end else if (tmo_cnt == TW'(TIMEOUT_CYC - 1)) begin
                    tmo_cnt   <= '0;
                    frame_err <= 1'b1;
                    err_code  <= ERR_TMO;
                    err_cnt   <= err_cnt + 16'd1;
                    state     <= HUNT;
                end else begin
                    tmo_cnt <= tmo_cnt + TW'(1);
                end
            end else begin
                tmo_cnt <= '0;
            end
`endif
        end
    end

endmodule
